sc_coin_pickup_ctrl: RTL
========================

// Module: sc_coin_pickup_ctrl
// PURPOSE
//  Drives the active-low load/clear controls of the 1-bit coin-type register, one instance per coin.
//  When the frog reaches a visible coin: take it (load, register -> 0), confirm, add score.
//  Waits a respawn time in game ticks, then restores the coin (clear, register -> DATA_FIXED_INITREGCOIN).
//  Sits between the collision logic / game tick generator and the coin register; score goes to the HUD.
// PARAMETERS
//  RESPAWN_TICKS  8'd100  game ticks between pickup and coin restore; 0 behaves as 1
//  TICK_W         8       width of the respawn tick counter (RESPAWN_TICKS < 2**TICK_W)
//  SCORE_W        8       width of the coin score counter
//  CONFIRM_MAX    2       cycles allowed for coinPresent to fall after the load pulse
// PORTS
//  SC_CoinCtrl_CLOCK_50          in   1        system clock, 50 MHz
//  SC_CoinCtrl_RESET_InHigh      in   1        reset, synchronous, active-high
//  SC_CoinCtrl_enable_InHigh     in   1        game running; low = pause
//  SC_CoinCtrl_tick_InHigh       in   1        game tick, 1-cycle pulse
//  SC_CoinCtrl_collision_InHigh  in   1        frog overlaps this coin cell (level)
//  SC_CoinCtrl_coinPresent_In    in   1        coin register output (1 = coin visible)
//  SC_CoinCtrl_loadCoin_OutLow   out  1        to register load_InLow; 1-cycle low pulse = take coin
//  SC_CoinCtrl_clearCoin_OutLow  out  1        to register clear_InLow; 1-cycle low pulse = restore coin
//  SC_CoinCtrl_score_Out         out  SCORE_W  coins collected, saturating
//  SC_CoinCtrl_scoreEvent_Out    out  1        1-cycle pulse when score_Out updates
//  SC_CoinCtrl_err_Out           out  1        sticky: coin did not drop within CONFIRM_MAX
// BEHAVIOUR
//  Reset (sync, any state): state=RESTORE, counter=0, score=0, err=0,
//    loadCoin_OutLow=1, clearCoin_OutLow=1, scoreEvent=0. Coin register also resets to 0 (no coin).
//  All outputs are registered. load and clear are never low in the same cycle.
//  FSM:
//   RESTORE: clearCoin_OutLow=0 for exactly one cycle, then IDLE.
//     The first cycle after reset release issues this pulse, making the coin visible.
//   IDLE: at an edge where enable=1, collision=1 and coinPresent=1 -> TAKE.
//     No change otherwise.
//   TAKE: loadCoin_OutLow=0 for exactly one cycle.
//     Latency is collision sampled at edge N -> load low in cycle N+1. Then CONFIRM.
//   CONFIRM: wait for coinPresent_In=0, for at most CONFIRM_MAX cycles.
//     On coinPresent_In=0: score+1, saturating at 2**SCORE_W-1.
//       scoreEvent=1 in the cycle score_Out changes (also pulses when saturated).
//     On timeout: err=1 (sticky until reset), no score.
//     Either way -> WAIT, counter=0.
//   WAIT: counter += 1 on each tick while enable=1; ticks while enable=0 are ignored (pause).
//     When counter reaches max(RESPAWN_TICKS,1) -> RESTORE.
//  Collision is ignored in TAKE/CONFIRM/WAIT/RESTORE: one score per coin.
//  enable=0 in TAKE/CONFIRM/RESTORE does not abort; pulses complete.
//  Simultaneous tick and collision in IDLE: collision handled, tick ignored.
//  Reset mid-WAIT or mid-pulse: pulse aborted next edge (outputs return to 1), restart at RESTORE.
// TESTING
//  T1 reset 3 cyc, release -> clear low exactly cycle 1, register out=1, load stays 1, score=0.
//  T2 IDLE, enable=1, collision=1 one cycle -> load low 1 cycle; next cycle coinPresent=0;
//     score 0->1 with scoreEvent pulse.
//  T3 RESPAWN_TICKS=3, 3 ticks after pickup -> clear low 1 cycle after 3rd tick; coin back, 1 score only.
//  T4 collision held high through WAIT; enable=0 during 2 ticks -> those ticks not counted;
//     no extra score.
//  T5 coinPresent forced 1 after load -> err=1 after CONFIRM_MAX cycles, score unchanged, respawn proceeds.
//  T6 SCORE_W=2, 5 pickups -> score sticks at 3; reset mid-WAIT -> score=0, clear pulse after release.

Source files
------------

// File: rtl/sc_coin_pickup_ctrl_if.sv
// sc_coin_pickup_ctrl_if: collision/tick inputs and coin register controls for one coin
interface sc_coin_pickup_ctrl_if #(parameter int SCORE_W = 8);
  logic               SC_CoinCtrl_enable_InHigh;
  logic               SC_CoinCtrl_tick_InHigh;
  logic               SC_CoinCtrl_collision_InHigh;
  logic               SC_CoinCtrl_coinPresent_In;
  logic               SC_CoinCtrl_loadCoin_OutLow;
  logic               SC_CoinCtrl_clearCoin_OutLow;
  logic [SCORE_W-1:0] SC_CoinCtrl_score_Out;
  logic               SC_CoinCtrl_scoreEvent_Out;
  logic               SC_CoinCtrl_err_Out;
  modport master (
    output SC_CoinCtrl_enable_InHigh, SC_CoinCtrl_tick_InHigh, SC_CoinCtrl_collision_InHigh,
           SC_CoinCtrl_coinPresent_In,
    input  SC_CoinCtrl_loadCoin_OutLow, SC_CoinCtrl_clearCoin_OutLow, SC_CoinCtrl_score_Out,
           SC_CoinCtrl_scoreEvent_Out, SC_CoinCtrl_err_Out
  );
  modport slave (
    input  SC_CoinCtrl_enable_InHigh, SC_CoinCtrl_tick_InHigh, SC_CoinCtrl_collision_InHigh,
           SC_CoinCtrl_coinPresent_In,
    output SC_CoinCtrl_loadCoin_OutLow, SC_CoinCtrl_clearCoin_OutLow, SC_CoinCtrl_score_Out,
           SC_CoinCtrl_scoreEvent_Out, SC_CoinCtrl_err_Out
  );
endinterface

// File: rtl/sc_coin_pickup_ctrl.sv
// sc_coin_pickup_ctrl: takes a visible coin on collision, scores it, and restores it after a respawn delay
module sc_coin_pickup_ctrl #(
  parameter int unsigned RESPAWN_TICKS = 100,
  parameter int          TICK_W        = 8,
  parameter int          SCORE_W       = 8,
  parameter int          CONFIRM_MAX   = 2
) (
  input logic                    SC_CoinCtrl_CLOCK_50,
  input logic                    SC_CoinCtrl_RESET_InHigh,
  sc_coin_pickup_ctrl_if.slave   io
);
  localparam int TGT = (RESPAWN_TICKS == 0) ? 1 : int'(RESPAWN_TICKS);
  localparam int CM  = (CONFIRM_MAX < 1) ? 1 : CONFIRM_MAX;
  localparam logic [TICK_W-1:0] TGT_LAST = TICK_W'(TGT - 1);
  localparam logic [TICK_W-1:0] CM_LAST  = TICK_W'(CM - 1);
  typedef enum logic [2:0] {RESTORE, IDLE, TAKE, CONFIRM, WAIT} state_t;
  state_t             state_q, state_d;
  logic [TICK_W-1:0]  cnt_q, cnt_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               err_q, err_d, load_q, load_d, clear_q, clear_d, ev_q, ev_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    score_d = score_q;
    err_d   = err_q;
    load_d  = 1'b1;
    clear_d = 1'b1;
    ev_d    = 1'b0;
    case (state_q)
      // after reset clear is still high, so RESTORE issues the pulse itself before leaving
      RESTORE: begin
        clear_d = !clear_q;
        state_d = clear_q ? RESTORE : IDLE;
      end
      IDLE: if (io.SC_CoinCtrl_enable_InHigh && io.SC_CoinCtrl_collision_InHigh &&
                io.SC_CoinCtrl_coinPresent_In) begin
        state_d = TAKE;
        load_d  = 1'b0;
      end
      TAKE: begin
        state_d = CONFIRM;
        cnt_d   = '0;
      end
      CONFIRM: if (!io.SC_CoinCtrl_coinPresent_In) begin
        score_d = &score_q ? score_q : score_q + 1'b1;
        ev_d    = 1'b1;
        state_d = WAIT;
        cnt_d   = '0;
      end else if (cnt_q == CM_LAST) begin
        err_d   = 1'b1;
        state_d = WAIT;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + 1'b1;
      end
      WAIT: if (io.SC_CoinCtrl_enable_InHigh && io.SC_CoinCtrl_tick_InHigh) begin
        if (cnt_q == TGT_LAST) begin
          state_d = RESTORE;
          clear_d = 1'b0;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = RESTORE;
    endcase
  end
  always_ff @(posedge SC_CoinCtrl_CLOCK_50) begin
    if (SC_CoinCtrl_RESET_InHigh) begin
      state_q <= RESTORE;
      cnt_q   <= '0;
      score_q <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b1;
      clear_q <= 1'b1;
      ev_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      err_q   <= err_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      ev_q    <= ev_d;
    end
  end
  assign io.SC_CoinCtrl_loadCoin_OutLow  = load_q;
  assign io.SC_CoinCtrl_clearCoin_OutLow = clear_q;
  assign io.SC_CoinCtrl_score_Out        = score_q;
  assign io.SC_CoinCtrl_scoreEvent_Out   = ev_q;
  assign io.SC_CoinCtrl_err_Out          = err_q;
endmodule
